// File: rtl/debug_dump_tx.sv
// debug_dump_tx
// Once the core halts, sends one fixed frame over the UART TX byte handshake:
// the 0xA5 header, the PC, the cycle count, R0..R(N_REGS-1) and
// M[0]..M(N_MEM_WORDS-1). Every word goes out MSB byte first.
//
// Ports
//   clk, reset          system clock; asynchronous active-low reset
//   i_halt              level, high while the core is halted
//   i_pc, i_cycle_count captured on the edge that leaves IDLE
//   o_reg_addr/i_reg_data  register-file debug port (1-cycle read latency)
//   o_mem_addr/i_mem_data  data-memory debug port (1-cycle read latency)
//   o_tx_data, o_tx_start, i_tx_done  UART TX byte handshake
//   o_busy, o_done      frame in progress / frame finished
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for i_halt; captures PC and cycle count, loads header
// SEND      | one-cycle o_tx_start carrying the current byte
// WAIT_DONE | waiting for i_tx_done; then next byte, next word, or finish
// RD_REQ    | debug read address presented to the register file or memory
// RD_CAP    | read data captured into the word register
// DONE      | frame sent; waits for i_halt low before rearming
module debug_dump_tx #(
   parameter int LEN         = 32,
   parameter int N_REGS      = 32,
   parameter int NB_REG_ADDR = 5,
   parameter int N_MEM_WORDS = 16,
   parameter int NB_MEM_ADDR = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_halt,
   input  logic [LEN-1:0]         i_pc,
   input  logic [LEN-1:0]         i_cycle_count,
   output logic [NB_REG_ADDR-1:0] o_reg_addr,
   input  logic [LEN-1:0]         i_reg_data,
   output logic [NB_MEM_ADDR-1:0] o_mem_addr,
   input  logic [LEN-1:0]         i_mem_data,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic                   o_busy,
   output logic                   o_done
);

   // Word slots: 0 header, 1 PC, 2 cycle count, then registers, then memory.
   localparam int REG_BASE    = 3;
   localparam int MEM_BASE    = REG_BASE + N_REGS;
   localparam int TOTAL_WORDS = MEM_BASE + N_MEM_WORDS;
   localparam int NB_IDX      = $clog2(TOTAL_WORDS + 1);

   localparam logic [NB_IDX-1:0] IDX_PC   = NB_IDX'(1);
   localparam logic [NB_IDX-1:0] IDX_CYC  = NB_IDX'(2);
   localparam logic [NB_IDX-1:0] IDX_REG0 = NB_IDX'(REG_BASE);
   localparam logic [NB_IDX-1:0] IDX_MEM0 = NB_IDX'(MEM_BASE);
   localparam logic [NB_IDX-1:0] IDX_END  = NB_IDX'(TOTAL_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_DONE,
      ST_RD_REQ,
      ST_RD_CAP,
      ST_DONE
   } state_t;

   state_t                   state_q, state_nxt;
   logic [LEN-1:0]           pc_q, cyc_q, word_q;
   logic [1:0]               byte_cnt_q;
   logic [NB_IDX-1:0]        word_idx_q;
   logic [NB_REG_ADDR-1:0]   reg_addr_q;
   logic [NB_MEM_ADDR-1:0]   mem_addr_q;
   logic [NB_IDX-1:0]        idx_nxt;
   logic                     last_byte;

   assign idx_nxt   = word_idx_q + NB_IDX'(1);
   assign last_byte = &byte_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:      if (i_halt) state_nxt = ST_SEND;
         ST_SEND:      state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (i_tx_done) begin
               if (!last_byte)             state_nxt = ST_SEND;
               else if (idx_nxt == IDX_END) state_nxt = ST_DONE;
               else if (idx_nxt < IDX_REG0) state_nxt = ST_SEND;
               else                         state_nxt = ST_RD_REQ;
            end
         end
         ST_RD_REQ:    state_nxt = ST_RD_CAP;
         ST_RD_CAP:    state_nxt = ST_SEND;
         ST_DONE:      if (!i_halt) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= '0;
         cyc_q      <= '0;
         word_q     <= '0;
         byte_cnt_q <= '0;
         word_idx_q <= '0;
         reg_addr_q <= '0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_halt) begin
                  pc_q       <= i_pc;
                  cyc_q      <= i_cycle_count;
                  word_q     <= {8'hA5, {(LEN-8){1'b0}}};
                  // header is a single byte, so start its count at the last slot
                  byte_cnt_q <= 2'd3;
                  word_idx_q <= '0;
               end
            end
            ST_WAIT_DONE: begin
               if (i_tx_done) begin
                  if (!last_byte) begin
                     word_q     <= word_q << 8;
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end else begin
                     word_idx_q <= idx_nxt;
                     byte_cnt_q <= '0;
                     if (idx_nxt == IDX_PC)
                        word_q <= pc_q;
                     else if (idx_nxt == IDX_CYC)
                        word_q <= cyc_q;
                     else if (idx_nxt < IDX_MEM0)
                        reg_addr_q <= NB_REG_ADDR'(idx_nxt - IDX_REG0);
                     else if (idx_nxt < IDX_END)
                        mem_addr_q <= NB_MEM_ADDR'(idx_nxt - IDX_MEM0);
                  end
               end
            end
            ST_RD_CAP: begin
               word_q <= (word_idx_q < IDX_MEM0) ? i_reg_data : i_mem_data;
            end
            default: ;
         endcase
      end
   end

   assign o_tx_data  = word_q[LEN-1 -: 8];
   assign o_tx_start = (state_q == ST_SEND);
   assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign o_done     = (state_q == ST_DONE);
   assign o_reg_addr = reg_addr_q;
   assign o_mem_addr = mem_addr_q;

endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Post-halt state dumper for the MIPS pipeline. When the processor reports HALT, it serializes a fixed frame over the UART transmitter's byte handshake: the PC, the cycle count, all 32 general-purpose registers and the first N_MEM_WORDS data-memory words. It sits between the processor top (register-file and data-memory debug read ports) and the UART TX byte interface. It is the transmit-side counterpart to the program loader that feeds the core.

## Interface
- LEN, 32, datapath word width; must be 32 (4 bytes per word)
- N_REGS, 32, registers dumped, indices 0..N_REGS-1
- NB_REG_ADDR, 5, register debug address width
- N_MEM_WORDS, 16, data-memory words dumped, word addresses 0..N_MEM_WORDS-1
- NB_MEM_ADDR, 4, memory debug word-address width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; all state and outputs forced to reset values immediately while low
- i_halt  in  1  level; high while the processor is halted
- i_pc  in  LEN  PC at halt; sampled on the edge leaving IDLE
- i_cycle_count  in  LEN  clock cycles executed; sampled with i_pc
- o_reg_addr  out  NB_REG_ADDR  register-file debug read address
- i_reg_data  in  LEN  register-file debug data; synchronous read, valid 1 cycle after address
- o_mem_addr  out  NB_MEM_ADDR  data-memory debug read word address
- i_mem_data  in  LEN  data-memory debug data; synchronous read, valid 1 cycle after address
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle request to the UART TX
- i_tx_done  in  1  one-cycle pulse from UART TX: byte fully sent
- o_busy  out  1  high from leaving IDLE until entering DONE
- o_done  out  1  high while in DONE

## Operation
- Frame order: 0xA5 header, PC, cycle count, R0..R(N_REGS-1), M[0]..M[N_MEM_WORDS-1]. Each word is sent MSB byte first. Defaults give 1+4+4+128+64 = 201 bytes.
- States: IDLE, SEND, WAIT_DONE, RD_REQ, RD_CAP, DONE.
- IDLE: if i_halt=1, latch i_pc and i_cycle_count, load the header into the byte register, then go to SEND.
- SEND: o_tx_start=1 for exactly this cycle, with o_tx_data = current byte. Next state is WAIT_DONE.
- WAIT_DONE: hold o_tx_data. On i_tx_done:
  - If more bytes remain in the current word: shift the word left 8, increment the byte counter, go to SEND.
  - Otherwise advance the word index:
    - PC and cycle-count words load from the latches and go to SEND.
    - Register and memory words go to RD_REQ.
    - After the last memory word, go to DONE.
- RD_REQ: drive o_reg_addr (register phase) or o_mem_addr (memory phase) with the index. Next state is RD_CAP.
- RD_CAP: capture i_reg_data or i_mem_data into the word register on the exit edge. Next state is SEND.
- DONE: o_done=1. Stay while i_halt=1, with no re-dump. When i_halt=0, return to IDLE.
- i_tx_done outside WAIT_DONE is ignored. i_halt deasserting mid-dump is ignored; the frame always completes.
- Address outputs hold their last value outside RD_REQ and RD_CAP.
- Reset values: state IDLE, o_tx_data=0, o_tx_start=0, o_reg_addr=0, o_mem_addr=0, o_busy=0, o_done=0. All counters and latches are 0.

## Timing
- o_tx_start and o_busy are decoded from state (Moore); no combinational path from any input.
- i_halt sampled high at edge k → o_tx_start=1 with o_tx_data=0xA5 in cycle k+1.
- i_tx_done at edge k, same word → next o_tx_start in cycle k+1.
- i_tx_done at edge k, next word is PC or cycle count → next o_tx_start in cycle k+1.
- i_tx_done at edge k, next word is register or memory → RD_REQ in k+1, RD_CAP in k+2, o_tx_start in k+3.
- Last i_tx_done at edge k → o_done=1 and o_busy=0 in cycle k+1.
- Reset asserted mid-frame → o_tx_start and o_busy drop immediately (asynchronously). The next frame restarts from the header once reset is released and i_halt=1.

## Test plan
- Reset and idle: hold reset=0 for 3 cycles, release with i_halt=0 for 20 cycles → all outputs 0, no o_tx_start.
- Full dump: R[i]=i*0x01010101, M[j]=0xC0DE0000+j, pc=0x0000004C, cycles=0x00000123, UART model returns i_tx_done 10 cycles after each start → 201 bytes; first 9 are A5 00 00 00 4C 00 00 01 23; R1 = 01 01 01 01; last is 0x0F; o_done=1.
- Read latency: at every register/memory word boundary → exactly 3 cycles from i_tx_done to o_tx_start, and o_reg_addr/o_mem_addr equal to the index during RD_REQ.
- Spurious done: pulse i_tx_done in SEND, RD_REQ and IDLE → ignored; byte sequence unchanged.
- Halt handling: drop i_halt at byte 50 → frame completes. Keep i_halt=1 after DONE → no second header. Toggle i_halt 0→1 → new frame starting with 0xA5.
- Reset mid-frame: assert reset at byte 100 → o_tx_start=0 and o_busy=0 within the same cycle. After release with i_halt=1 → new frame from 0xA5 with freshly latched PC.
